uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - Receive side of the team UART: deserialises 8N1 / 8E1 / 8O1 frames from the serial line
//    into bytes and flags parity and framing errors.
//  - Counterpart to the UART transmitter. Shares its frame format: start=0, 8 data bits LSB first,
//    optional parity, stop=1.
//  - Sits between the pad-side rx line and the byte consumer. The byte interface has no backpressure.
// PARAMETERS
//  - CLKS_PER_BIT  8  clk cycles per serial bit; must be even and >= 4.
//  - CNT_W         4  bit-timer width; must satisfy 2**CNT_W >= CLKS_PER_BIT.
// PORTS
//  - clk         in   1  system clock; the only clock.
//  - rst         in   1  reset: synchronous, active-high.
//  - rx_in       in   1  asynchronous serial line; idles at 1.
//  - par_en      in   1  1 = frame carries a parity bit.
//  - par_typ     in   1  0 = even parity, 1 = odd parity.
//  - p_data      out  8  last received byte; held until the next good frame.
//  - data_valid  out  1  1-cycle pulse; p_data is new and the frame is good.
//  - par_err     out  1  1-cycle pulse; parity mismatch.
//  - stop_err    out  1  1-cycle pulse; stop bit sampled 0.
//  - busy        out  1  1 from start-edge detect until the frame completes.
// BEHAVIOUR
//  - Reset values (sync rst): every output is 0, p_data = 8'h00, state = IDLE, rx_sync = 1.
//    A reset mid-frame aborts the frame silently.
//  - Synchroniser: rx_in passes through a 2-FF synchroniser (rx_s, reset value 1). All decisions use rx_s.
//  - Start detect: falling edge of rx_s (previous 1, current 0) in IDLE at cycle T.
//    At T, latch par_en and par_typ, clear the bit timer, assert busy, go to START.
//  - Sample points: T + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
//    - k = 0: start bit. k = 1..8: data bits d0..d7. k = 9: parity if enabled.
//    - Stop bit: k = 10 with parity, k = 9 without.
//  - States IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
//    - START: if rx_s = 1 at the sample point, the start was a glitch. Go to IDLE with busy = 0 and no pulse.
//    - DATA: shift into a shift register, LSB first. A 3-bit counter leaves after 8 samples.
//    - PARITY: entered only if the latched par_en = 1. Expected bit = ^data ^ latched par_typ.
//    - STOP: the stop sample is the decision point. Return to IDLE in the following cycle,
//      so a start edge arriving in the second half of the stop bit is accepted.
//  - Outputs are registered one cycle after the stop sample (cycle S+1):
//    - stop = 1 and parity ok: data_valid = 1 and p_data is updated.
//    - Parity bad: par_err = 1.
//    - stop = 0: stop_err = 1.
//    - Both errors may pulse together. data_valid never pulses with an error, and p_data is then not updated.
//  - busy: falls in cycle S+1.
//  - Latency: rx_in start edge to data_valid is 2 + CLKS_PER_BIT/2 + (9 + par_en)*CLKS_PER_BIT + 1 cycles.
//  - par_en and par_typ changing mid-frame have no effect on the current frame.
//  - A line held at 0 (break) produces stop_err once. A new frame then requires the line to return to 1 first.
// CONFIGURATION
//  - Macro UART_RX_ERR_CNT_EN.
//    - Defined: adds output err_cnt [7:0]. It increments on every cycle where par_err or stop_err pulses
//      (+1 even if both pulse), saturates at 8'hFF, and is cleared by rst.
//    - Undefined: no port and no logic. All other behaviour is identical.
// STRUCTURE
//  - Package uart_pkg holds:
//    - the state enum: IDLE, START, DATA, PARITY, STOP;
//    - the PAR_EVEN/PAR_ODD constants (0/1);
//    - DATA_W = 8, shared with the transmitter.
//  - Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect, with outputs rx_s and fall.
//  - FSM, bit timer, shift register and error logic stay in uart_rx.
// TESTING  (CLKS_PER_BIT = 8, bit period = 8 clk)
//  - par_en = 0, send 0xA5 -> exactly one data_valid pulse, p_data = 0xA5, no err pulses,
//    latency = 2 + 4 + 72 + 1 = 79 cycles from the start edge.
//  - par_en = 1, par_typ = 0, send 0x3C with parity 0 -> data_valid and p_data = 0x3C.
//    Same frame with parity 1 -> par_err pulse, no data_valid, p_data unchanged.
//  - par_en = 0, send 0x5A with stop bit 0 -> stop_err pulse, no data_valid. Then idle 1 and send 0x01 -> p_data = 0x01.
//  - rx_in low for 3 cycles only -> busy rises then falls, no pulses, state returns to IDLE.
//  - Two back-to-back frames 0x11 and 0xEE, odd parity -> two data_valid pulses in order, correct data, no errors.
//  - rst asserted during the DATA state of 0x77 -> all outputs 0 the next cycle.
//    A following frame 0x42 -> p_data = 0x42; with UART_RX_ERR_CNT_EN, err_cnt stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity selectors and data width.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity bit the transmitter places after the data for the given parity type.
  function automatic logic parity_bit(logic [DATA_W-1:0] data, logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the synchronised value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic rx_s_q;
  logic prev_q;

  // Line idles high, so all stages reset to 1 to avoid a false start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      rx_s_q <= meta_q;
      prev_q <= rx_s_q;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8E1/8O1 deserialiser with parity and framing error pulses.
// Optional saturating error counter output err_cnt when UART_RX_ERR_CNT_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stop_err,
`ifdef UART_RX_ERR_CNT_EN
  output logic              busy,
  output logic [7:0]        err_cnt
`else
  output logic              busy
`endif
);

  localparam logic [CNT_W-1:0] HalfM1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FullM1 = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;
  logic              sample;

  // First sample lands mid start bit; later ones are a full bit period apart.
  assign sample = (state_q == START) ? (cnt_q == HalfM1) : (cnt_q == FullM1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = sample ? '0 : cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          par_en_d  = par_en;
          par_typ_d = par_typ;
          par_bad_d = 1'b0;
          bit_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (sample) begin
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          par_bad_d = (rx_s != parity_bit(shift_q, par_typ_q));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          perr_d  = par_bad_q;
          serr_d  = ~rx_s;
          if (rx_s && !par_bad_q) begin
            valid_d  = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = perr_q;
  assign stop_err   = serr_q;
  assign busy       = (state_q != IDLE);

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if ((perr_q || serr_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected pulses are queued as frames are sent and checked on output.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
`ifdef UART_RX_ERR_CNT_EN
    .busy       (busy),
    .err_cnt    (err_cnt)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned last_dv_cyc = 0;
  int unsigned pulse_cnt = 0;
  logic [7:0]  model_pd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (data_valid || par_err || stop_err) begin
      pulse_cnt++;
      if (data_valid) last_dv_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b p_data=%h, required no pulse",
                 data_valid, par_err, stop_err, p_data);
      end else begin
        e = sb.pop_front();
        if ({data_valid, par_err, stop_err, p_data} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got dv=%b pe=%b se=%b p_data=%h, required dv=%b pe=%b se=%b p_data=%h",
                   data_valid, par_err, stop_err, p_data, e.dv, e.pe, e.se, e.pd);
        end
      end
    end
  end

  // Independent frame model: decides which pulse a frame must produce.
  task automatic expect_frame(input logic [7:0] d, input bit with_par, input bit typ,
                              input bit pbit, input bit sbit);
    exp_t e;
    e.pe = with_par && (pbit != ((^d) ^ typ));
    e.se = !sbit;
    e.dv = !e.pe && !e.se;
    if (e.dv) model_pd = d;
    e.pd = model_pd;
    sb.push_back(e);
  endtask

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  // Caller is always at posedge+1; the frame ends at posedge+1 as well.
  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit pbit,
                            input bit sbit, input bit flip);
    last_start_cyc = cyc;
    rx_in = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      if (flip && i == 4) begin
        par_en  = ~par_en;
        par_typ = ~par_typ;
      end
      rx_in = d[i];
      bit_wait();
    end
    if (with_par) begin
      rx_in = pbit;
      bit_wait();
    end
    if (flip) begin
      par_en  = ~par_en;
      par_typ = ~par_typ;
    end
    rx_in = sbit;
    bit_wait();
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    par_en = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b, required 0", data_valid); end
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b, required 0", par_err); end
    if (stop_err !== 1'b0) begin n_fail++; $display("FAIL reset_se: got %b, required 0", stop_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (p_data !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h, required 00", p_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
`ifdef UART_RX_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_errcnt: got %h, required 00", err_cnt); end
`endif
  endtask

  task automatic test_basic();
    int unsigned p0;
    p0 = pulse_cnt;
    par_en = 1'b0;
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    wait_drain();
    n_checks += 5;
    if (sb.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d left, required 0", sb.size()); end
    if (p_data !== 8'hA5) begin n_fail++; $display("FAIL basic_pdata: got %h, required a5", p_data); end
    if (last_dv_cyc - last_start_cyc != 79)
      begin n_fail++; $display("FAIL basic_latency: got %0d, required 79", last_dv_cyc - last_start_cyc); end
    if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d, required 1", pulse_cnt - p0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_parity();
    par_en = 1'b1;
    par_typ = 1'b0;
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    n_checks += 2;
    if (last_dv_cyc - last_start_cyc != 87)
      begin n_fail++; $display("FAIL par_latency: got %0d, required 87", last_dv_cyc - last_start_cyc); end
    if (p_data !== 8'h3C) begin n_fail++; $display("FAIL par_good_pdata: got %h, required 3c", p_data); end
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    wait_drain();
    n_checks += 2;
    if (sb.size() != 0) begin n_fail++; $display("FAIL par_drain: %0d left, required 0", sb.size()); end
    if (p_data !== 8'h3C) begin n_fail++; $display("FAIL par_bad_pdata: got %h, required 3c", p_data); end
  endtask

  task automatic test_stop_err();
    par_en = 1'b0;
    expect_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(16);
    n_checks++;
    if (p_data !== 8'h3C) begin n_fail++; $display("FAIL stop_pdata_held: got %h, required 3c", p_data); end
    expect_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    wait_drain();
    n_checks += 2;
    if (sb.size() != 0) begin n_fail++; $display("FAIL stop_drain: %0d left, required 0", sb.size()); end
    if (p_data !== 8'h01) begin n_fail++; $display("FAIL stop_next_pdata: got %h, required 01", p_data); end
  endtask

  task automatic test_break();
    int unsigned p0;
    p0 = pulse_cnt;
    par_en = 1'b0;
    expect_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (15 * CPB) @(posedge clk);
    #1;
    idle(20);
    n_checks += 3;
    if (sb.size() != 0) begin n_fail++; $display("FAIL break_drain: %0d left, required 0", sb.size()); end
    if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL break_pulses: got %0d, required 1", pulse_cnt - p0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b, required 0", busy); end
  endtask

  task automatic test_glitch();
    int unsigned p0;
    bit seen_busy;
    p0 = pulse_cnt;
    seen_busy = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    @(posedge clk);
    #1;
    n_checks += 3;
    if (seen_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b, required 1", seen_busy); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b, required 0", busy); end
    if (pulse_cnt != p0) begin n_fail++; $display("FAIL glitch_pulses: got %0d, required 0", pulse_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    par_en = 1'b1;
    par_typ = 1'b1;
    expect_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_frame(8'hEE, 1'b1, 1'b1, 1'b1, 1'b1);
    // First frame flips par_en/par_typ mid-frame; the latched settings must still apply.
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'hEE, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    wait_drain();
    n_checks += 2;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left, required 0", sb.size()); end
    if (p_data !== 8'hEE) begin n_fail++; $display("FAIL b2b_pdata: got %h, required ee", p_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h77;
`ifdef UART_RX_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'h03) begin n_fail++; $display("FAIL errcnt_before: got %h, required 03", err_cnt); end
`endif
    par_en = 1'b0;
    rx_in = 1'b0;
    bit_wait();
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      bit_wait();
    end
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_pd = 8'h00;
    n_checks += 5;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dv: got %b, required 0", data_valid); end
    if (par_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pe: got %b, required 0", par_err); end
    if (stop_err !== 1'b0) begin n_fail++; $display("FAIL midrst_se: got %b, required 0", stop_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (p_data !== 8'h00) begin n_fail++; $display("FAIL midrst_pdata: got %h, required 00", p_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    expect_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    wait_drain();
    n_checks += 2;
    if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_drain: %0d left, required 0", sb.size()); end
    if (p_data !== 8'h42) begin n_fail++; $display("FAIL midrst_next_pdata: got %h, required 42", p_data); end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL errcnt_after: got %h, required 00", err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
